// File: rtl/uart_tx_stream_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UART TX byte stream
// among NUM_SRC AXI-Stream sources, with an optional source-ID header.
module uart_tx_stream_arbiter #(
  parameter int          NUM_SRC  = 4,
  parameter int          HDR_EN   = 1,
  parameter logic [7:0]  HDR_BASE = 8'hA0,
  parameter int          MAX_PKT  = 256,
  localparam int         IDW      = $clog2(NUM_SRC),
  localparam int         CW       = $clog2(MAX_PKT)
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [8*NUM_SRC-1:0] s_axis_tdata,
  input  logic [NUM_SRC-1:0]   s_axis_tvalid,
  input  logic [NUM_SRC-1:0]   s_axis_tlast,
  output logic [NUM_SRC-1:0]   s_axis_tready,
  output logic [7:0]           m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic [IDW-1:0]       grant_id,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  state_t         state_q;
  logic [IDW-1:0] rr_q;
  logic [IDW-1:0] grant_q;
  logic [CW-1:0]  cnt_q;

  logic [7:0]     src_byte [NUM_SRC];
  logic           hit;
  logic [IDW-1:0] pick;
  logic [IDW-1:0] nxt;
  logic           g_valid;
  logic           g_last;
  logic           rel;

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      src_byte[i] = s_axis_tdata[8*i +: 8];
    end
  end

  // Scan upward from rr_q with wrap; first asserted tvalid wins.
  always_comb begin
    int idx;
    idx  = 0;
    hit  = 1'b0;
    pick = rr_q;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = (int'(rr_q) + k) % NUM_SRC;
      if (!hit && s_axis_tvalid[idx]) begin
        hit  = 1'b1;
        pick = IDW'(idx);
      end
    end
  end

  assign g_valid = s_axis_tvalid[grant_q];
  assign g_last  = s_axis_tlast[grant_q];
  assign nxt     = (grant_q == IDW'(NUM_SRC-1)) ? '0 : grant_q + 1'b1;
  assign rel     = g_last || (cnt_q == CW'(MAX_PKT-1));

  always_comb begin
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = 8'h00;
    s_axis_tready = '0;
    unique case (state_q)
      HDR: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = HDR_BASE | 8'(grant_q);
      end
      DATA: begin
        m_axis_tvalid          = g_valid;
        m_axis_tdata           = src_byte[grant_q];
        s_axis_tready[grant_q] = m_axis_tready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= IDLE;
      rr_q    <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (hit) begin
            grant_q <= pick;
            cnt_q   <= '0;
            state_q <= (HDR_EN != 0) ? HDR : DATA;
          end
        end
        HDR: begin
          if (m_axis_tready) state_q <= DATA;
        end
        DATA: begin
          if (g_valid && m_axis_tready) begin
            if (rel) begin
              state_q <= IDLE;
              rr_q    <= nxt;
              cnt_q   <= '0;
            end else begin
              cnt_q   <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant_id = grant_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_stream_arbiter.sv
// Directed bench: per-source byte queues feed either the header or the
// headerless instance; captured output bytes are compared to hand tables.
module tb_uart_tx_stream_arbiter;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        m_tready;
  logic        sel;
  logic [31:0] sv_data;
  logic [3:0]  sv_valid;
  logic [3:0]  sv_last;

  logic [3:0]  tv_a, tv_b, rdy_a, rdy_b, rdy_s;
  logic [7:0]  md_a, md_b, md_s;
  logic        mv_a, mv_b, mv_s;
  logic [1:0]  gid_a, gid_b, gid_s;
  logic        busy_a, busy_b, busy_s;

  int          n_chk = 0;
  int          n_err = 0;
  logic [8:0]  mem [4][512];
  int          rp [4] = '{default: 0};
  int          wp [4] = '{default: 0};
  bit          adv [4];
  logic [7:0]  outq [$];
  logic [7:0]  exq [$];

  always #5 aclk = ~aclk;

  assign tv_a   = sel ? 4'b0 : sv_valid;
  assign tv_b   = sel ? sv_valid : 4'b0;
  assign rdy_s  = sel ? rdy_b : rdy_a;
  assign md_s   = sel ? md_b : md_a;
  assign mv_s   = sel ? mv_b : mv_a;
  assign gid_s  = sel ? gid_b : gid_a;
  assign busy_s = sel ? busy_b : busy_a;

  uart_tx_stream_arbiter #(
    .NUM_SRC(4), .HDR_EN(1), .HDR_BASE(8'hA0), .MAX_PKT(256)
  ) u_dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(sv_data), .s_axis_tvalid(tv_a),
    .s_axis_tlast(sv_last), .s_axis_tready(rdy_a),
    .m_axis_tdata(md_a), .m_axis_tvalid(mv_a),
    .m_axis_tready(m_tready),
    .grant_id(gid_a), .busy(busy_a)
  );

  uart_tx_stream_arbiter #(
    .NUM_SRC(4), .HDR_EN(0), .HDR_BASE(8'hA0), .MAX_PKT(256)
  ) u_dut_nh (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(sv_data), .s_axis_tvalid(tv_b),
    .s_axis_tlast(sv_last), .s_axis_tready(rdy_b),
    .m_axis_tdata(md_b), .m_axis_tvalid(mv_b),
    .m_axis_tready(m_tready),
    .grant_id(gid_b), .busy(busy_b)
  );

  // Handshakes are sampled mid-cycle; sources advance just after the edge.
  always begin
    @(negedge aclk);
    for (int i = 0; i < 4; i++) adv[i] = sv_valid[i] & rdy_s[i];
    if (mv_s && m_tready) outq.push_back(md_s);
    @(posedge aclk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (adv[i]) rp[i]++;
      sv_valid[i] = (rp[i] < wp[i]);
      if (rp[i] < wp[i]) {sv_last[i], sv_data[8*i +: 8]} = mem[i][rp[i]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #2;
  endtask

  task automatic push(input int s, input logic [7:0] d, input bit l);
    mem[s][wp[s]] = {l, d};
    wp[s]++;
  endtask

  task automatic drain(input string tag);
    int n;
    for (n = 0; n < 2000; n++) begin
      tick();
      #1;
      if (rp[0] == wp[0] && rp[1] == wp[1] && rp[2] == wp[2] &&
          rp[3] == wp[3] && !busy_s) break;
    end
    chk({tag, "_drain"}, 32'(n < 2000), 32'd1);
  endtask

  task automatic wait_out(input string tag, input logic [7:0] b);
    int n;
    for (n = 0; n < 50; n++) begin
      tick();
      #1;
      if (mv_s && md_s == b) break;
    end
    chk({tag, "_seen"}, 32'(n < 50), 32'd1);
  endtask

  task automatic cmp_out(input string tag);
    chk({tag, "_len"}, 32'(outq.size()), 32'(exq.size()));
    for (int i = 0; i < exq.size(); i++) begin
      if (i < outq.size())
        chk($sformatf("%s_b%0d", tag, i), 32'(outq[i]), 32'(exq[i]));
    end
    outq.delete();
    exq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    aresetn  = 1'b0;
    m_tready = 1'b1;
    sel      = 1'b0;
    sv_valid = '0;
    sv_last  = '0;
    sv_data  = '0;
    repeat (2) tick();
    #1;
    chk("rst_mv", 32'(mv_a), 32'd0);
    chk("rst_rdy", 32'(rdy_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_gid", 32'(gid_a), 32'd0);
    aresetn = 1'b1;

    // 1: single source with header
    push(1, 8'h11, 0); push(1, 8'h22, 0); push(1, 8'h33, 1);
    wait_out("t1", 8'h33);
    chk("t1_busy_pre", 32'(busy_a), 32'd1);
    chk("t1_gid", 32'(gid_a), 32'd1);
    tick();
    #1;
    chk("t1_busy_post", 32'(busy_a), 32'd0);
    drain("t1");
    exq = '{8'hA1, 8'h11, 8'h22, 8'h33};
    cmp_out("t1");

    // 2: src0 and src2 pending across reset release
    aresetn = 1'b0;
    push(0, 8'h01, 0); push(0, 8'h02, 1);
    push(2, 8'h21, 0); push(2, 8'h22, 0); push(2, 8'h23, 1);
    tick();
    #1;
    chk("t2_rst_mv", 32'(mv_a), 32'd0);
    chk("t2_rst_rdy", 32'(rdy_a), 32'd0);
    chk("t2_rst_gid", 32'(gid_a), 32'd0);
    tick();
    aresetn = 1'b1;
    drain("t2");
    exq = '{8'hA0, 8'h01, 8'h02, 8'hA2, 8'h21, 8'h22, 8'h23};
    cmp_out("t2");
    push(1, 8'h71, 1);
    push(3, 8'h73, 1);
    drain("t2rr");
    exq = '{8'hA3, 8'h73, 8'hA1, 8'h71};
    cmp_out("t2rr");

    // 3: 300-byte stream, forced release after 256 payload bytes
    for (int i = 0; i < 300; i++) push(3, 8'(i), i == 299);
    drain("t3");
    exq.push_back(8'hA3);
    for (int i = 0; i < 256; i++) exq.push_back(8'(i));
    exq.push_back(8'hA3);
    for (int i = 256; i < 300; i++) exq.push_back(8'(i));
    cmp_out("t3");

    // 4: downstream stalls in header and mid-payload
    m_tready = 1'b0;
    push(0, 8'h41, 0); push(0, 8'h42, 0); push(0, 8'h43, 1);
    wait_out("t4h", 8'hA0);
    repeat (5) begin
      tick();
      #1;
      chk("t4_hdr_mv", 32'(mv_a), 32'd1);
      chk("t4_hdr_md", 32'(md_a), 32'hA0);
      chk("t4_hdr_rdy", 32'(rdy_a), 32'd0);
    end
    chk("t4_gid", 32'(gid_a), 32'd0);
    m_tready = 1'b1;
    tick();
    tick();
    #1;
    m_tready = 1'b0;
    repeat (5) begin
      tick();
      #1;
      chk("t4_dat_mv", 32'(mv_a), 32'd1);
      chk("t4_dat_md", 32'(md_a), 32'h42);
      chk("t4_dat_rdy", 32'(rdy_a), 32'd0);
    end
    m_tready = 1'b1;
    drain("t4");
    exq = '{8'hA0, 8'h41, 8'h42, 8'h43};
    cmp_out("t4");

    // 5: reset pulse in the middle of a src1 packet
    push(1, 8'hB1, 0); push(1, 8'hB2, 0);
    push(1, 8'hB3, 0); push(1, 8'hB4, 1);
    wait_out("t5", 8'hB2);
    m_tready = 1'b0;
    aresetn  = 1'b0;
    push(0, 8'hC1, 0); push(0, 8'hC2, 1);
    tick();
    #1;
    chk("t5_rst_mv", 32'(mv_a), 32'd0);
    chk("t5_rst_rdy", 32'(rdy_a), 32'd0);
    chk("t5_rst_busy", 32'(busy_a), 32'd0);
    aresetn  = 1'b1;
    m_tready = 1'b1;
    drain("t5");
    exq = '{8'hA1, 8'hB1, 8'hA0, 8'hC1, 8'hC2,
            8'hA1, 8'hB2, 8'hB3, 8'hB4};
    cmp_out("t5");

    // 6: headerless instance, payload straight after arbitration
    sel = 1'b1;
    push(2, 8'h5A, 0); push(2, 8'h5B, 1);
    begin
      int n;
      for (n = 0; n < 50; n++) begin
        tick();
        #1;
        if (busy_b) break;
      end
      chk("t6_busy", 32'(n < 50), 32'd1);
    end
    chk("t6_first_mv", 32'(mv_b), 32'd1);
    chk("t6_first_md", 32'(md_b), 32'h5A);
    chk("t6_gid", 32'(gid_b), 32'd2);
    drain("t6");
    exq = '{8'h5A, 8'h5B};
    cmp_out("t6");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
